fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register. It drives the fetch-PC / decode-instruction interface consumed by decode.
//  - Holds the fetch PC (pcF) and loads decode's npc whenever a fetch completes.
//  - Fetches from instruction memory over a req/ack handshake with variable latency.
//  - Presents instrD/pcD/validD to decode and honours stall/flush from the hazard unit.
// PARAMETERS
//  RESET_PC   32'h0000_3000  pcF value loaded by reset
//  NOP_INSTR  32'h0000_0000  word driven on instrD for bubbles
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   reset: asynchronous assertion, active-low
//  npc         in   32  next PC from decode; already resolves branch/jump using pcF (delay-slot semantics)
//  stallD      in   1   hazard unit: hold decode register and fetch PC
//  flushD      in   1   hazard unit: kill instruction entering decode
//  imem_req    out  1   fetch request
//  imem_addr   out  32  {pcF[31:2],2'b00}; stable while imem_req=1 and no ack
//  imem_ack    in   1   fetch complete; may be asserted in the same cycle as imem_req
//  imem_rdata  in   32  instruction word, valid when imem_ack=1
//  pcF         out  32  current fetch PC
//  instrD      out  32  instruction in decode
//  pcD         out  32  PC of instrD
//  validD      out  1   instrD is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pcF=RESET_PC, instrD=NOP_INSTR, pcD=0, validD=0, imem_req=0.
//   - Hold buffer cleared; state=S_IDLE.
//  FSM S_IDLE -> S_FETCH -> S_HOLD:
//   S_IDLE:  imem_req=0; next cycle -> S_FETCH (one idle cycle after reset release).
//   S_FETCH: imem_req=1, imem_addr from pcF.
//    - No ack: D loads bubble (NOP, validD=0) unless stallD; pcF holds.
//    - Ack & !stallD: D<={rdata,pcF,1}; pcF<=npc; stay S_FETCH.
//      Zero-wait memory therefore gives 1 instr/cycle.
//    - Ack & stallD: rdata/pcF captured in hold buffer; pcF holds; D unchanged; -> S_HOLD.
//   S_HOLD:  imem_req=0.
//    - stallD: everything holds.
//    - !stallD: D<=buffer; pcF<=npc; -> S_FETCH.
//  stallD with no ack in S_FETCH:
//   - D and pcF hold.
//   - Request stays asserted; an issued request is never withdrawn.
//  flushD (priority over load, ignored while stallD=1):
//   - D<={NOP_INSTR,0,0}.
//   - An instruction being accepted that cycle is discarded, but pcF still advances to npc.
//  Decode's npc is sampled only on the advancing edge; no other cycle uses it.
//  npc[1:0] is ignored (word-aligned addresses only).
//  PC arithmetic is 32-bit and wraps modulo 2^32 with no flag.
//  Reset asserted mid-request:
//   - imem_req drops immediately.
//   - A late ack arriving after reset release is ignored in S_IDLE.
// STRUCTURE
//  defines.vh gets:
//   - FETCH_STATE_LENGTH and S_IDLE/S_FETCH/S_HOLD encodings.
//   - RESET_PC and NOP_INSTR defaults.
//  Sub-module if_id_reg holds instr/pc/valid with load, hold and flush controls.
//  FSM, PC register and hold buffer live in fetch_unit.
// TESTING
//  1. rst=0 mid-operation -> pcF=0x3000, validD=0, instrD=0, imem_req=0 at once.
//     Release -> 1 cycle later imem_req=1, addr=0x3000.
//  2. ack every cycle, npc=pcF+4 -> instrD/pcD stream 0x3000,0x3004,0x3008 on consecutive cycles, validD=1.
//  3. ack 3 cycles after req -> imem_addr and pcF stable for 3 cycles.
//     During the wait: validD=0, instrD=0. Word appears on the cycle after ack.
//  4. ack with stallD=1 for 2 cycles -> imem_req=0, instrD unchanged.
//     On release: buffered word/PC enter D and pcF=npc.
//  5. flushD=1 coincident with ack of 0x3004 -> validD=0, instrD=0, pcF=npc (0x3008).
//  6. npc=0x3100 (taken branch) when fetch of 0x3008 acks -> next imem_addr=0x3100; 0x3008 still enters D (delay slot).

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int FETCH_STATE_LENGTH = 2;

  typedef enum logic [FETCH_STATE_LENGTH-1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load, hold (no load) and flush-to-bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  // Flush wins over load; the caller gates flush with stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: fetch PC, imem handshake FSM, stall hold buffer, IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         npc,
  input  logic                stallD,
  input  logic                flushD,
  fetch_unit_if.master        imem,
  output logic [31:0]         pcF,
  output logic [31:0]         instrD,
  output logic [31:0]         pcD,
  output logic                validD
);

  fetch_state_e r_state, w_state_n;
  logic [31:0]  r_pcF;
  logic [31:0]  r_buf_instr;
  logic [31:0]  r_buf_pc;

  logic        w_req;
  logic        w_pc_adv;
  logic        w_buf_cap;
  logic        w_d_load;
  logic        w_d_flush;
  logic [31:0] w_d_instr;
  logic [31:0] w_d_pc;
  logic        w_d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_req     = 1'b0;
    w_pc_adv  = 1'b0;
    w_buf_cap = 1'b0;
    w_d_load  = 1'b0;
    w_d_instr = NOP_INSTR;
    w_d_pc    = 32'h0;
    w_d_valid = 1'b0;
    w_d_flush = flushD & ~stallD;
    unique case (r_state)
      S_IDLE: w_state_n = S_FETCH;
      S_FETCH: begin
        w_req = 1'b1;
        if (imem.ack) begin
          if (stallD) begin
            // Decode can't take the word yet; park it so the request can retire.
            w_buf_cap = 1'b1;
            w_state_n = S_HOLD;
          end else begin
            w_d_load  = 1'b1;
            w_d_instr = imem.rdata;
            w_d_pc    = r_pcF;
            w_d_valid = 1'b1;
            w_pc_adv  = 1'b1;
          end
        end else if (!stallD) begin
          w_d_load = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stallD) begin
          w_d_load  = 1'b1;
          w_d_instr = r_buf_instr;
          w_d_pc    = r_buf_pc;
          w_d_valid = 1'b1;
          w_pc_adv  = 1'b1;
          w_state_n = S_FETCH;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // pcF advances even when the accepted word is flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_pcF <= RESET_PC;
    else if (w_pc_adv) r_pcF <= word_align(npc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_instr <= 32'h0;
      r_buf_pc    <= 32'h0;
    end else if (w_buf_cap) begin
      r_buf_instr <= imem.rdata;
      r_buf_pc    <= r_pcF;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_d_load),
    .i_flush (w_d_flush),
    .i_instr (w_d_instr),
    .i_pc    (w_d_pc),
    .i_valid (w_d_valid),
    .o_instr (instrD),
    .o_pc    (pcD),
    .o_valid (validD)
  );

  assign imem.req  = w_req;
  assign imem.addr = word_align(r_pcF);
  assign pcF       = r_pcF;

endmodule
